// File: rtl/accum_alu_pkg.sv
// Shared function codes and FSM state encoding for the accumulator ALU.
package accum_alu_pkg;

    localparam logic [2:0] FN_ADD  = 3'b000;
    localparam logic [2:0] FN_MUL  = 3'b001;
    localparam logic [2:0] FN_SHL  = 3'b010;
    localparam logic [2:0] FN_HOLD = 3'b011;
    localparam logic [2:0] FN_SUB  = 3'b100;
    localparam logic [2:0] FN_ACC  = 3'b101;
    localparam logic [2:0] FN_CLR  = 3'b110;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/accum_alu_seq_multiplier.sv
// Iterative shift-add multiplier: one partial-product step per clock, WIDTH steps per product.
// The done pulse and product are combinational, so the caller can capture the result on the last step edge.
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    logic          running;
    logic [CW-1:0] count;
    logic [RW-1:0] mcand;
    logic [RW-1:0] partial;
    logic [RW-1:0] partial_next;
    logic [WIDTH-1:0] mplier;

    assign partial_next = partial + (mplier[0] ? mcand : '0);
    assign done         = running && (count == CW'(WIDTH - 1));
    assign product      = partial_next;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            running <= 1'b0;
            count   <= '0;
            mcand   <= '0;
            partial <= '0;
            mplier  <= '0;
        end else if (start) begin
            running <= 1'b1;
            count   <= '0;
            partial <= '0;
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
        end else if (running) begin
            partial <= partial_next;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            count   <= count + CW'(1);
            if (done)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/accum_alu_seq.sv
// Accumulator ALU with valid/ready issue, chained B operand and a multi-cycle multiply.
// Define ACCUM_ALU_SATURATE_EN to clamp overflowing ACC/SHL/SUB results instead of wrapping.
module accum_alu_seq
    import accum_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [WIDTH-1:0]   Data,
    input  logic [2:0]         Function,
    input  logic               InValid,
    output logic               InReady,
    output logic [2*WIDTH-1:0] ALUout,
    output logic               OutValid,
    output logic               Busy,
    output logic               Overflow
);

    localparam int RW = 2 * WIDTH;

`ifdef ACCUM_ALU_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    logic [0:0]    state;
    logic          issue;
    logic          mul_start;
    logic          mul_done;
    logic [RW-1:0] mul_product;
    logic [WIDTH-1:0] op_b;
    logic [RW-1:0] a_ext;
    logic [RW-1:0] b_ext;
    logic [RW:0]   acc_sum;
    logic [RW-1:0] shl_val;
    logic          shl_lost;
    logic          sub_borrow;
    logic [RW-1:0] alu_result;
    logic          alu_ovf;

    assign InReady   = (state == ST_IDLE);
    assign Busy      = (state == ST_MUL);
    assign issue     = InValid && InReady;
    assign mul_start = issue && (Function == FN_MUL);

    assign op_b       = ALUout[WIDTH-1:0];
    assign a_ext      = {{WIDTH{1'b0}}, Data};
    assign b_ext      = {{WIDTH{1'b0}}, op_b};
    assign acc_sum    = {1'b0, ALUout} + {1'b0, a_ext};
    assign shl_val    = b_ext << Data;
    // Shifting back and comparing catches any set bit pushed past the top.
    assign shl_lost   = ((shl_val >> Data) != b_ext);
    assign sub_borrow = (op_b > Data);

    seq_multiplier #(.WIDTH(WIDTH)) u_mult (
        .Clock   (Clock),
        .Reset   (Reset),
        .start   (mul_start),
        .a       (Data),
        .b       (op_b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        alu_result = ALUout;
        alu_ovf    = 1'b0;
        case (Function)
            FN_ADD: alu_result = a_ext + b_ext;
            FN_SHL: begin
                alu_ovf    = shl_lost;
                alu_result = (SATURATE && shl_lost) ? '1 : shl_val;
            end
            FN_SUB: begin
                alu_ovf    = sub_borrow;
                alu_result = (SATURATE && sub_borrow) ? '0 : (a_ext - b_ext);
            end
            FN_ACC: begin
                alu_ovf    = acc_sum[RW];
                alu_result = (SATURATE && acc_sum[RW]) ? '1 : acc_sum[RW-1:0];
            end
            FN_CLR: alu_result = '0;
            default: alu_result = ALUout;
        endcase
    end

    // Reset has priority, so an issue on a reset edge is simply dropped.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ST_IDLE;
            ALUout   <= '0;
            OutValid <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            OutValid <= 1'b0;
            if (state == ST_IDLE) begin
                if (issue) begin
                    if (Function == FN_MUL) begin
                        state <= ST_MUL;
                    end else begin
                        ALUout   <= alu_result;
                        Overflow <= alu_ovf;
                        OutValid <= 1'b1;
                    end
                end
            end else if (mul_done) begin
                ALUout   <= mul_product;
                Overflow <= 1'b0;
                OutValid <= 1'b1;
                state    <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_accum_alu_seq.sv
// Directed bench for accum_alu_seq at WIDTH=4; expectations follow ACCUM_ALU_SATURATE_EN when defined.
module tb_accum_alu_seq;
    import accum_alu_pkg::*;

`ifdef ACCUM_ALU_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [2:0] fn;
        logic [3:0] data;
        logic [7:0] exp_out;
        logic       exp_ovf;
    } vec_t;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] Data = '0;
    logic [2:0] Function = '0;
    logic       InValid = 1'b0;
    logic       InReady;
    logic [7:0] ALUout;
    logic       OutValid;
    logic       Busy;
    logic       Overflow;

    int checks = 0;
    int fails  = 0;
    int pulses;
    vec_t vecs[23];

    accum_alu_seq #(.WIDTH(4)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Data     (Data),
        .Function (Function),
        .InValid  (InValid),
        .InReady  (InReady),
        .ALUout   (ALUout),
        .OutValid (OutValid),
        .Busy     (Busy),
        .Overflow (Overflow)
    );

    always #5 Clock = ~Clock;

    task automatic applyStimulus(input logic valid, input logic [2:0] fn, input logic [3:0] d);
        InValid  = valid;
        Function = fn;
        Data     = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    initial begin
        vecs[0]  = '{FN_ADD,  4'hF, 8'h0F, 1'b0};
        vecs[1]  = '{FN_SHL,  4'h2, 8'h3C, 1'b0};
        vecs[2]  = '{FN_CLR,  4'h0, 8'h00, 1'b0};
        vecs[3]  = '{FN_ADD,  4'hF, 8'h0F, 1'b0};
        vecs[4]  = '{FN_SHL,  4'h5, SAT ? 8'hFF : 8'hE0, 1'b1};
        vecs[5]  = '{FN_CLR,  4'h0, 8'h00, 1'b0};
        vecs[6]  = '{FN_ADD,  4'hF, 8'h0F, 1'b0};
        vecs[7]  = '{FN_SHL,  4'h4, 8'hF0, 1'b0};
        vecs[8]  = '{FN_ACC,  4'hE, 8'hFE, 1'b0};
        vecs[9]  = '{FN_ACC,  4'h3, SAT ? 8'hFF : 8'h01, 1'b1};
        vecs[10] = '{FN_CLR,  4'h0, 8'h00, 1'b0};
        vecs[11] = '{FN_ADD,  4'h5, 8'h05, 1'b0};
        vecs[12] = '{FN_SUB,  4'h2, SAT ? 8'h00 : 8'hFD, 1'b1};
        vecs[13] = '{FN_HOLD, 4'h0, SAT ? 8'h00 : 8'hFD, 1'b0};
        vecs[14] = '{FN_CLR,  4'h0, 8'h00, 1'b0};
        vecs[15] = '{FN_ADD,  4'h9, 8'h09, 1'b0};
        vecs[16] = '{FN_SUB,  4'h9, 8'h00, 1'b0};
        vecs[17] = '{FN_ADD,  4'h3, 8'h03, 1'b0};
        vecs[18] = '{FN_ACC,  4'hF, 8'h12, 1'b0};
        vecs[19] = '{FN_SHL,  4'h0, 8'h02, 1'b0};
        vecs[20] = '{FN_SHL,  4'h7, SAT ? 8'hFF : 8'h00, 1'b1};
        vecs[21] = '{3'b111,  4'h5, SAT ? 8'hFF : 8'h00, 1'b0};
        vecs[22] = '{FN_ADD,  4'hF, SAT ? 8'h1E : 8'h0F, 1'b0};

        // Reset for two cycles, then a plain ADD.
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        checkOutput("rst_aluout", ALUout, 8'h00);
        checkOutput("rst_outvalid", OutValid, 1'b0);
        checkOutput("rst_busy", Busy, 1'b0);
        checkOutput("rst_overflow", Overflow, 1'b0);
        checkOutput("rst_inready", InReady, 1'b1);
        Reset = 1'b0;
        applyStimulus(1'b1, FN_ADD, 4'h3);
        step();
        checkOutput("add3_aluout", ALUout, 8'h03);
        checkOutput("add3_outvalid", OutValid, 1'b1);
        checkOutput("add3_overflow", Overflow, 1'b0);
        applyStimulus(1'b0, FN_ADD, 4'h0);
        step();
        checkOutput("add3_pulse_end", OutValid, 1'b0);

        // Multiply 5 * 3 with an ignored ADD request while busy.
        applyStimulus(1'b1, FN_MUL, 4'h5);
        step();
        applyStimulus(1'b1, FN_ADD, 4'h1);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            checkOutput("mul_busy", Busy, 1'b1);
            checkOutput("mul_inready", InReady, 1'b0);
            checkOutput("mul_hold", ALUout, 8'h03);
            if (OutValid) pulses++;
            step();
        end
        applyStimulus(1'b0, FN_ADD, 4'h0);
        checkOutput("mul_result", ALUout, 8'h0F);
        checkOutput("mul_outvalid", OutValid, 1'b1);
        checkOutput("mul_done_busy", Busy, 1'b0);
        checkOutput("mul_done_inready", InReady, 1'b1);
        checkOutput("mul_overflow", Overflow, 1'b0);
        checkOutput("mul_early_pulses", pulses, 0);
        step();
        checkOutput("mul_pulse_end", OutValid, 1'b0);
        checkOutput("mul_add_ignored", ALUout, 8'h0F);

        // Reset and a request on the same edge: the request is dropped.
        Reset = 1'b1;
        applyStimulus(1'b1, FN_ADD, 4'h5);
        step();
        checkOutput("rst_issue_aluout", ALUout, 8'h00);
        checkOutput("rst_issue_outvalid", OutValid, 1'b0);
        checkOutput("rst_issue_inready", InReady, 1'b1);
        Reset = 1'b0;

        // Back-to-back single-cycle issues, one per clock.
        for (int i = 0; i < 23; i++) begin
            applyStimulus(1'b1, vecs[i].fn, vecs[i].data);
            step();
            checkOutput($sformatf("vec%0d_aluout", i), ALUout, vecs[i].exp_out);
            checkOutput($sformatf("vec%0d_overflow", i), Overflow, vecs[i].exp_ovf);
            checkOutput($sformatf("vec%0d_outvalid", i), OutValid, 1'b1);
        end
        applyStimulus(1'b0, FN_ADD, 4'h0);
        step();
        checkOutput("vec_pulse_end", OutValid, 1'b0);

        // Reset arriving on the second cycle of a multiply aborts it.
        applyStimulus(1'b1, FN_MUL, 4'h3);
        step();
        applyStimulus(1'b0, FN_ADD, 4'h0);
        checkOutput("abort_busy", Busy, 1'b1);
        pulses = 0;
        if (OutValid) pulses++;
        step();
        if (OutValid) pulses++;
        Reset = 1'b1;
        step();
        checkOutput("abort_aluout", ALUout, 8'h00);
        checkOutput("abort_busy_clr", Busy, 1'b0);
        checkOutput("abort_inready", InReady, 1'b1);
        checkOutput("abort_overflow", Overflow, 1'b0);
        if (OutValid) pulses++;
        Reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (OutValid) pulses++;
        end
        checkOutput("abort_no_pulse", pulses, 0);
        checkOutput("abort_aluout_stays", ALUout, 8'h00);
        checkOutput("abort_idle", Busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
